// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcode constants,
// controller state encoding and datapath mux-select enums.
package cpu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_CMP   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_class_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_t;

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch through
// write-back, drives datapath strobes/selects and counts retired instructions.
module multicycle_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op_class,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    ctrl_state_t state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Natural 32-bit wrap is the intended overflow behaviour.
    assign instret_d = instret_q + {31'd0, retire};
    assign instret   = instret_q;
    assign state     = state_q;

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        alu_a_sel    = ALU_A_RS1;
        alu_b_sel    = 1'b0;
        alu_op_class = ALU_ADD;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        trap         = 1'b0;

        case (state_q)
            ST_BOOT: state_d = ST_FETCH;

            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
                if (imem_ready) state_d = ST_DECODE;
            end

            ST_DECODE: begin
                case (opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD,
                    OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_FENCE:
                        state_d = ST_EXEC;
                    OPC_JALR: state_d = (funct3 == 3'b000) ? ST_EXEC : ST_TRAP;
                    default:  state_d = ST_TRAP;
                endcase
            end

            ST_EXEC: begin
                case (opcode)
                    OPC_OP: begin
                        alu_op_class = ALU_FUNCT;
                        state_d      = ST_WB;
                    end
                    OPC_OP_IMM: begin
                        alu_b_sel    = 1'b1;
                        alu_op_class = ALU_FUNCT;
                        state_d      = ST_WB;
                    end
                    OPC_LUI: begin
                        alu_a_sel = ALU_A_ZERO;
                        alu_b_sel = 1'b1;
                        state_d   = ST_WB;
                    end
                    OPC_AUIPC: begin
                        alu_a_sel = ALU_A_PC;
                        alu_b_sel = 1'b1;
                        state_d   = ST_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel = 1'b1;
                        state_d   = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        alu_op_class = ALU_CMP;
                        pc_we        = 1'b1;
                        pc_src       = branch_taken ? PC_IMM : PC_PLUS4;
                        retire       = 1'b1;
                        state_d      = ST_FETCH;
                    end
                    OPC_JAL: begin
                        rf_we   = 1'b1;
                        wb_sel  = WB_PC4;
                        pc_we   = 1'b1;
                        pc_src  = PC_IMM;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OPC_JALR: begin
                        alu_b_sel = 1'b1;
                        rf_we     = 1'b1;
                        wb_sel    = WB_PC4;
                        pc_we     = 1'b1;
                        pc_src    = PC_ALU;
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    OPC_FENCE: begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end

            // Address operands stay selected so the ALU result is stable for the whole access.
            ST_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = (opcode == OPC_STORE);
                alu_b_sel = 1'b1;
                if (dmem_ready) begin
                    if (opcode == OPC_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                wb_sel  = (opcode == OPC_LOAD) ? WB_LOAD : WB_ALU;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end

            ST_TRAP: trap = 1'b1;

            default: state_d = ST_BOOT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle comparison against a
// phase-sequence reference model, table-driven latency vectors and corner cases.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_b_sel, rf_we, trap;
    logic [1:0]  pc_src, alu_a_sel, alu_op_class, wb_sel;
    logic [31:0] instret;
    logic [2:0]  state;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_op_class(alu_op_class), .rf_we(rf_we),
        .wb_sel(wb_sel), .trap(trap), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic [1:0] alu_op_class;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       trap;
        logic [2:0] state;
    } outs_t;

    outs_t act;
    assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_a_sel,
                  alu_b_sel, alu_op_class, rf_we, wb_sel, trap, state};

    // Debug state numbering follows the listed state order.
    localparam int P_BOOT = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                   P_MEM = 4, P_WB = 5, P_TRAP = 6;
    localparam int C_OP = 0, C_OPIMM = 1, C_LUI = 2, C_AUIPC = 3, C_LOAD = 4,
                   C_STORE = 5, C_BRANCH = 6, C_JAL = 7, C_JALR = 8, C_FENCE = 9,
                   C_BAD = 10;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instret = '0;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
        end
    endtask

    function automatic int classify(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            7'b0110011: return C_OP;
            7'b0010011: return C_OPIMM;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BRANCH;
            7'b1101111: return C_JAL;
            7'b1100111: return (f3 == 3'b000) ? C_JALR : C_BAD;
            7'b0001111: return C_FENCE;
            default:    return C_BAD;
        endcase
    endfunction

    function automatic outs_t exp_out(input int ph, input int c, input logic ir,
                                      input logic dr, input logic tk);
        outs_t o;
        o = '0;
        o.state = 3'(ph);
        case (ph)
            P_FETCH: begin o.imem_req = 1'b1; o.ir_we = ir; end
            P_EXEC: begin
                case (c)
                    C_OP:    o.alu_op_class = 2'd2;
                    C_OPIMM: begin o.alu_b_sel = 1'b1; o.alu_op_class = 2'd2; end
                    C_LUI:   begin o.alu_a_sel = 2'd2; o.alu_b_sel = 1'b1; end
                    C_AUIPC: begin o.alu_a_sel = 2'd1; o.alu_b_sel = 1'b1; end
                    C_LOAD, C_STORE: o.alu_b_sel = 1'b1;
                    C_BRANCH: begin
                        o.alu_op_class = 2'd1; o.pc_we = 1'b1; o.pc_src = tk ? 2'd1 : 2'd0;
                    end
                    C_JAL: begin
                        o.rf_we = 1'b1; o.wb_sel = 2'd2; o.pc_we = 1'b1; o.pc_src = 2'd1;
                    end
                    C_JALR: begin
                        o.alu_b_sel = 1'b1; o.rf_we = 1'b1; o.wb_sel = 2'd2;
                        o.pc_we = 1'b1; o.pc_src = 2'd2;
                    end
                    C_FENCE: o.pc_we = 1'b1;
                    default: ;
                endcase
            end
            P_MEM: begin
                o.dmem_req  = 1'b1;
                o.dmem_we   = (c == C_STORE);
                o.alu_b_sel = 1'b1;
                o.pc_we     = (c == C_STORE) && dr;
            end
            P_WB: begin
                o.rf_we = 1'b1; o.pc_we = 1'b1; o.wb_sel = (c == C_LOAD) ? 2'd1 : 2'd0;
            end
            P_TRAP: o.trap = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // Builds the expected phase list for one instruction, then drives and checks it cycle by cycle.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic tk,
                             input int iw, input int dw, input int trap_cycles,
                             input int stop_after, output int lat);
        int ph[$];
        int c;
        int p;
        logic last;
        c = classify(opc, f3);
        repeat (iw + 1) ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        if (c == C_BAD) begin
            repeat (trap_cycles) ph.push_back(P_TRAP);
        end else begin
            ph.push_back(P_EXEC);
            if (c == C_LOAD || c == C_STORE) repeat (dw + 1) ph.push_back(P_MEM);
            if (c == C_OP || c == C_OPIMM || c == C_LUI || c == C_AUIPC || c == C_LOAD)
                ph.push_back(P_WB);
        end
        lat = (c == C_BAD) ? iw + 2 : ph.size();
        for (int k = 0; k < ph.size(); k++) begin
            if (stop_after >= 0 && k >= stop_after) break;
            @(negedge clk);
            p = ph[k];
            last = (k == ph.size() - 1) ? 1'b1 : (ph[k + 1] != p);
            opcode       = opc;
            funct3       = f3;
            imem_ready   = (p == P_FETCH) ? last : 1'($urandom_range(1, 0));
            dmem_ready   = (p == P_MEM)   ? last : 1'($urandom_range(1, 0));
            branch_taken = (p == P_EXEC)  ? tk   : 1'($urandom_range(1, 0));
            #1;
            chk("outputs", 64'(act), 64'(exp_out(p, c, imem_ready, dmem_ready, tk)));
            chk("instret", 64'(instret), 64'(exp_instret));
            if (c != C_BAD && k == ph.size() - 1) exp_instret = exp_instret + 32'd1;
        end
        $display("instr op=%b f3=%0d taken=%0d iw=%0d dw=%0d latency=%0d instret_exp=%h",
                 opc, f3, tk, iw, dw, lat, exp_instret);
    endtask

    // Reset asserted mid-cycle with late readies driven high; released one cycle later.
    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("reset_outputs", 64'(act), 64'd0);
        chk("reset_instret", 64'(instret), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_outputs", 64'(act), 64'd0);
        exp_instret = '0;
        $display("reset applied and released");
    endtask

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic       tk;
        int         iw;
        int         dw;
        int         lat;
        logic       traps;
    } vec_t;

    vec_t vecs[18];
    int   lat;

    initial begin
        vecs[0]  = '{7'b0010011, 3'd0, 1'b0, 0, 0, 4, 1'b0}; // ADDI
        vecs[1]  = '{7'b0110011, 3'd0, 1'b0, 0, 0, 4, 1'b0}; // ADD
        vecs[2]  = '{7'b0110111, 3'd0, 1'b0, 0, 0, 4, 1'b0}; // LUI
        vecs[3]  = '{7'b0010111, 3'd0, 1'b0, 0, 0, 4, 1'b0}; // AUIPC
        vecs[4]  = '{7'b0000011, 3'd2, 1'b0, 0, 0, 5, 1'b0}; // LW
        vecs[5]  = '{7'b0000011, 3'd2, 1'b0, 0, 3, 8, 1'b0}; // LW, ready 3 late
        vecs[6]  = '{7'b0100011, 3'd2, 1'b0, 0, 0, 4, 1'b0}; // SW
        vecs[7]  = '{7'b0100011, 3'd2, 1'b0, 0, 2, 6, 1'b0}; // SW, ready 2 late
        vecs[8]  = '{7'b1100011, 3'd0, 1'b1, 0, 0, 3, 1'b0}; // BEQ taken
        vecs[9]  = '{7'b1100011, 3'd0, 1'b0, 0, 0, 3, 1'b0}; // BEQ not taken
        vecs[10] = '{7'b1101111, 3'd0, 1'b0, 0, 0, 3, 1'b0}; // JAL
        vecs[11] = '{7'b1100111, 3'd0, 1'b0, 0, 0, 3, 1'b0}; // JALR
        vecs[12] = '{7'b0001111, 3'd0, 1'b0, 0, 0, 3, 1'b0}; // FENCE
        vecs[13] = '{7'b0010011, 3'd5, 1'b0, 2, 0, 6, 1'b0}; // ADDI, fetch 2 late
        vecs[14] = '{7'b0000011, 3'd0, 1'b0, 1, 2, 8, 1'b0}; // LB, both late
        vecs[15] = '{7'b1100111, 3'd1, 1'b0, 0, 0, 2, 1'b1}; // JALR bad funct3
        vecs[16] = '{7'b1110011, 3'd0, 1'b0, 0, 0, 2, 1'b1}; // SYSTEM
        vecs[17] = '{7'b1111111, 3'd0, 1'b0, 1, 0, 3, 1'b1}; // illegal

        do_reset();
        foreach (vecs[i]) begin
            run_instr(vecs[i].opc, vecs[i].f3, vecs[i].tk, vecs[i].iw, vecs[i].dw, 3, -1, lat);
            chk("latency", 64'(lat), 64'(vecs[i].lat));
            if (vecs[i].traps) do_reset();
        end

        // Long trap hold: trap stays high and instret is frozen.
        run_instr(7'b0010011, 3'd0, 1'b0, 0, 0, 0, -1, lat);
        run_instr(7'b1110011, 3'd0, 1'b0, 0, 0, 100, -1, lat);
        do_reset();
        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, 0, -1, lat);
        run_instr(7'b1111111, 3'd3, 1'b0, 0, 0, 100, -1, lat);
        do_reset();

        // Reset in the middle of a stalled store, then a fresh fetch right after release.
        run_instr(7'b0010011, 3'd0, 1'b0, 0, 0, 0, -1, lat);
        run_instr(7'b0100011, 3'd2, 1'b0, 0, 5, 0, 5, lat);
        do_reset();
        run_instr(7'b0010011, 3'd0, 1'b0, 0, 0, 0, -1, lat);
        chk("post_reset_latency", 64'(lat), 64'd4);

        // Counter wrap: preload all-ones while FETCH is stalled, then retire once.
        exp_instret = 32'hFFFF_FFFF;
        fork
            begin
                @(posedge clk);
                #1 force dut.instret_q = 32'hFFFF_FFFF;
                @(posedge clk);
                #1 release dut.instret_q;
            end
        join_none
        run_instr(7'b0010011, 3'd0, 1'b0, 2, 0, 0, -1, lat);
        run_instr(7'b1101111, 3'd0, 1'b0, 0, 0, 0, -1, lat);
        chk("wrap_then_one", 64'(exp_instret), 64'd1);

        // Randomized instruction stream against the phase model.
        for (int n = 0; n < 60; n++) begin
            logic [6:0] opc;
            logic [2:0] f3;
            int         r;
            logic [6:0] ops[11];
            ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                    7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111,
                    7'b1110011};
            r   = $urandom_range(12, 0);
            opc = (r < 11) ? ops[r] : 7'($urandom);
            f3  = $urandom_range(1, 0) ? 3'd0 : 3'($urandom);
            run_instr(opc, f3, 1'($urandom_range(1, 0)), $urandom_range(3, 0),
                      $urandom_range(3, 0), 3, -1, lat);
            if (classify(opc, f3) == C_BAD) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
